// File: rtl/imem_arb_pkg.sv
// Shared types and defaults for the instruction-memory port arbiter.
package imem_arb_pkg;

  localparam int unsigned LD_BURST_MAX_DEFAULT = 4;
  localparam int unsigned CNT_WIDTH_DEFAULT    = 16;

  // Which requester owns the memory port in the current cycle.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LOAD  = 2'd2
  } imem_owner_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts one per cycle with inc high, sticks at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Synchronous clear, increment unless already saturated
  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port synchronous-read instruction memory between
// the fetch path (reads) and the loader/debug path (writes).
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE = `ADDRESS_SIZE,
  parameter int unsigned DATA_SIZE    = `DATA_SIZE,
  parameter int unsigned LD_BURST_MAX = LD_BURST_MAX_DEFAULT,
  parameter int unsigned CNT_WIDTH    = CNT_WIDTH_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    if_req,
  input  logic [ADDRESS_SIZE-1:0] if_addr,
  input  logic                    if_flush,
  output logic [DATA_SIZE-1:0]    if_rdata,
  output logic                    if_rvalid,
  output logic                    im_stall_c,
  input  logic                    ld_req,
  input  logic [ADDRESS_SIZE-1:0] ld_addr,
  input  logic [DATA_SIZE-1:0]    ld_wdata,
  output logic                    ld_gnt,
  output logic [ADDRESS_SIZE-1:0] im_address,
  output logic                    im_write_enable,
  output logic [DATA_SIZE-1:0]    im_write_data,
  input  logic [DATA_SIZE-1:0]    im_read_data,
  output logic [CNT_WIDTH-1:0]    stall_count,
  output logic [CNT_WIDTH-1:0]    write_count
);

  localparam int unsigned         STREAK_W   = $clog2(LD_BURST_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(LD_BURST_MAX);

  imem_owner_t             owner;
  logic                    fetch_grant;
  logic [STREAK_W-1:0]     ld_streak;
  logic [STREAK_W-1:0]     ld_streak_next;
  logic                    rd_pending;
  logic [ADDRESS_SIZE-1:0] addr_q;
  logic [DATA_SIZE-1:0]    rdata_q;
  logic                    cnt_clear;

  // Pick the port owner: loader wins unless it has used its burst while fetch waits; nothing granted in reset
  always_comb begin
    owner = OWN_NONE;
    if (reset_n) begin
      if (ld_req && !(if_req && (ld_streak == STREAK_MAX))) begin
        owner = OWN_LOAD;
      end else if (if_req) begin
        owner = OWN_FETCH;
      end
    end
  end

  // Drive the memory port, the grant/stall strobes and the next loader streak
  always_comb begin
    fetch_grant     = 1'b0;
    ld_gnt          = 1'b0;
    im_write_enable = 1'b0;
    im_write_data   = '0;
    im_address      = addr_q;
    ld_streak_next  = '0;
    unique case (owner)
      OWN_LOAD: begin
        ld_gnt          = 1'b1;
        im_write_enable = 1'b1;
        im_write_data   = ld_wdata;
        im_address      = ld_addr;
        ld_streak_next  = (ld_streak == STREAK_MAX) ? ld_streak : ld_streak + 1'b1;
      end
      OWN_FETCH: begin
        fetch_grant = 1'b1;
        im_address  = if_addr;
      end
      default: ;
    endcase
    im_stall_c = reset_n && if_req && !fetch_grant;
  end

  // Read response straight from the memory; the holding register keeps the last word when no response
  always_comb begin
    if_rvalid = reset_n && rd_pending && !if_flush;
    if_rdata  = if_rvalid ? im_read_data : rdata_q;
  end

  // Per-cycle state: streak, outstanding read, held address and held read data
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ld_streak  <= '0;
      rd_pending <= 1'b0;
      addr_q     <= '0;
      rdata_q    <= '0;
    end else begin
      ld_streak  <= ld_streak_next;
      rd_pending <= fetch_grant;
      addr_q     <= im_address;
      rdata_q    <= if_rdata;
    end
  end

  assign cnt_clear = !reset_n;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clock (clock),
    .clear (cnt_clear),
    .inc   (im_stall_c),
    .count (stall_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_write_cnt (
    .clock (clock),
    .clear (cnt_clear),
    .inc   (ld_gnt),
    .count (write_count)
  );

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single-port, synchronous-read instruction memory between two requesters: the IF-stage fetch path (reads) and the program loader/debug path (writes).
- Grants at most one access per cycle and tracks the one outstanding read.
- Drops read responses squashed by a PC redirect.
- Drives a stall toward the pipeline while fetch is denied.
- Sits between the fetch stage and the instruction memory macro.

Parameters:
- ADDRESS_SIZE, `ADDRESS_SIZE (32): memory address width.
- DATA_SIZE, `DATA_SIZE (32): instruction/word width.
- LD_BURST_MAX, 4: maximum consecutive loader grants before fetch is given one slot.
- CNT_WIDTH, 16: width of the saturating performance counters.

Ports:
- clock  in  1  clock
- reset_n  in  1  synchronous active-low reset
- if_req  in  1  fetch requests a read this cycle
- if_addr  in  ADDRESS_SIZE  fetch read address
- if_flush  in  1  redirect this cycle; the in-flight read response is discarded
- if_rdata  out  DATA_SIZE  fetched instruction
- if_rvalid  out  1  if_rdata valid this cycle
- im_stall_c  out  1  fetch denied this cycle (if_req and no fetch grant)
- ld_req  in  1  loader write request
- ld_addr  in  ADDRESS_SIZE  loader write address
- ld_wdata  in  DATA_SIZE  loader write data
- ld_gnt  out  1  loader write performed this cycle
- im_address  out  ADDRESS_SIZE  memory address
- im_write_enable  out  1  memory write strobe
- im_write_data  out  DATA_SIZE  memory write data
- im_read_data  in  DATA_SIZE  memory read data, valid one cycle after the address
- stall_count  out  CNT_WIDTH  cycles with im_stall_c=1, saturating
- write_count  out  CNT_WIDTH  loader writes performed, saturating

Behaviour:
- Reset: reset_n is synchronous and active-low; clock is clock.
- Reset values: if_rvalid=0, if_rdata=0, ld_gnt=0, im_write_enable=0, im_address=0, im_write_data=0, im_stall_c=0, both counters=0, ld_streak=0, rd_pending=0.
- Reset mid-operation: any in-flight read is dropped. No if_rvalid in the cycle after reset is released.
- Arbitration (combinational from the current inputs and registered ld_streak):
  - ld_req && !(if_req && ld_streak==LD_BURST_MAX) -> loader granted.
  - Else if_req -> fetch granted.
  - Else idle.
- Loader grant, same cycle:
  - im_write_enable=1, im_address=ld_addr, im_write_data=ld_wdata, ld_gnt=1.
  - ld_streak increments, saturating at LD_BURST_MAX.
- Fetch grant, same cycle:
  - im_address=if_addr, im_write_enable=0.
  - rd_pending<=1 at the clock edge.
  - ld_streak<=0.
- Idle cycle: im_write_enable=0, im_address holds its last value, ld_streak<=0, rd_pending<=0.
- Response, one cycle after a fetch grant: if_rvalid=rd_pending && !if_flush, and if_rdata=im_read_data.
  - if_rdata holds its last value when if_rvalid=0.
  - Implement if_rdata/if_rvalid combinationally from rd_pending and im_read_data, with a holding register for if_rdata.
- Throughput: back-to-back fetch grants give one instruction per cycle at latency 1.
- Stall: im_stall_c = if_req && !fetch_grant. It is asserted in the cycle the loader wins.
- Flush: if_flush kills only the response arriving in that cycle. A fetch grant in the same cycle, to the redirected address, proceeds normally.
- Read/write ordering: a read granted in cycle N returns the pre-write data even if the loader writes the same address in N+1.
- Counters increment by 1 per qualifying cycle and hold at all-ones.
- There are never simultaneous grants; im_write_enable and fetch grant are mutually exclusive.

Decomposition:
- Shared package imem_arb_pkg:
  - typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD} imem_owner_t.
  - LD_BURST_MAX default constant.
- ADDRESS_SIZE/DATA_SIZE come from defines.vh.
- One sub-module, sat_counter (parameter WIDTH; inputs inc, clear), instantiated twice for stall_count and write_count.

Test Plan:
- Reset sequence: hold reset_n=0 for 3 cycles with if_req=1 and ld_req=1. Required: all outputs 0. First if_rvalid no earlier than 2 cycles after release.
- Fetch streaming: if_req=1 with if_addr 0x0,0x4,0x8, memory returning 0x11,0x22,0x33. Required: if_rvalid=1 on the 3 following cycles with if_rdata 0x11,0x22,0x33, and im_stall_c=0 throughout.
- Loader fairness (LD_BURST_MAX=4): ld_req=1 and if_req=1 held for 10 cycles. Required grant pattern L,L,L,L,F,L,L,L,L,F. im_stall_c=1 on the L cycles. stall_count=8, write_count=8.
- Flush: fetch granted at 0x40 in cycle N; if_flush=1 in N+1 with if_addr=0x100. Required: if_rvalid=0 in N+1 and im_address=0x100 in N+1. In N+2, if_rvalid=1 with data[0x100].
- Read-after-write: loader writes 0xDEADBEEF to 0x20, then fetch reads 0x20 in the next cycle. Required: if_rdata=0xDEADBEEF. A read granted one cycle before the write returns the old value.
- Counter saturation (CNT_WIDTH=4): 20 loader-only grants. Required: write_count=0xF, and it holds there.
